// File: rtl/scan_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : scan_pkg
//  Description : Shared types and sizes for the scan sequencer. Holds the
//                sequencer state encoding, the channel count, the width of a
//                single channel value and the width of the packed result.
//  Revision    : 1.0 - initial release
// ============================================================================
package scan_pkg;

    localparam int NUM_CH = 8;
    localparam int CH_W   = 3;
    localparam int RES_W  = NUM_CH * CH_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DWELL = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage : scan_pkg
`default_nettype wire

// File: rtl/next_chan_finder.sv
`default_nettype none
// ============================================================================
//  Module      : next_chan_finder
//  Description : Combinational search for the lowest enabled channel whose
//                index is strictly above a given index. Setting i_below_zero
//                treats the current index as -1, so the search returns the
//                lowest enabled channel overall.
//  Ports       : i_mask       - channel enable mask
//                i_cur        - current channel index
//                i_below_zero - search from below index 0
//                o_next       - next enabled index (0 when none found)
//                o_found      - a qualifying channel exists
//  Revision    : 1.0 - initial release
// ============================================================================
module next_chan_finder
    import scan_pkg::*;
(
    input  logic [NUM_CH-1:0] i_mask,
    input  logic [CH_W-1:0]   i_cur,
    input  logic              i_below_zero,
    output logic [CH_W-1:0]   o_next,
    output logic              o_found
);

    // Scan from the top down so the last qualifying hit is the lowest index.
    always_comb begin
        o_next  = '0;
        o_found = 1'b0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (i_mask[k] && (i_below_zero || (CH_W'(k) > i_cur))) begin
                o_next  = CH_W'(k);
                o_found = 1'b1;
            end
        end
    end

endmodule : next_chan_finder
`default_nettype wire

// File: rtl/scan_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : scan_sequencer
//  Description : Drives the select of a shared 8:1 3-bit mux. On a start
//                request it visits every enabled channel in ascending order,
//                holds each select for dwell+1 cycles and captures the mux
//                output at the final edge of each dwell into a packed result.
//  Ports       : clk          - system clock, rising edge
//                rst          - synchronous active-high reset
//                i_start      - scan request, honoured only when idle
//                i_dwell      - extra hold cycles per channel (latched)
//                i_chan_en    - channel enable mask (latched)
//                i_mux_out    - mux output fed back from o_sel3
//                o_sel3       - mux select
//                o_busy       - scan in progress
//                o_done       - one-cycle completion pulse
//                o_result     - captured values, channel k at [3k+2:3k]
//                o_valid_mask - channels captured in the last scan
//  Revision    : 1.0 - initial release
// ============================================================================
module scan_sequencer
    import scan_pkg::*;
#(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    input  logic [DWELL_W-1:0] i_dwell,
    input  logic [NUM_CH-1:0]  i_chan_en,
    input  logic [CH_W-1:0]    i_mux_out,
    output logic [CH_W-1:0]    o_sel3,
    output logic               o_busy,
    output logic               o_done,
    output logic [RES_W-1:0]   o_result,
    output logic [NUM_CH-1:0]  o_valid_mask
);

    state_t              r_state;
    logic [DWELL_W-1:0]  r_cnt;
    logic [DWELL_W-1:0]  r_dwell;
    logic [NUM_CH-1:0]   r_mask;
    logic [CH_W-1:0]     r_sel3;
    logic                r_busy;
    logic                r_done;
    logic [RES_W-1:0]    r_result;
    logic [NUM_CH-1:0]   r_valid;

    state_t              w_nxt_state;
    logic [DWELL_W-1:0]  w_nxt_cnt;
    logic [DWELL_W-1:0]  w_nxt_dwell;
    logic [NUM_CH-1:0]   w_nxt_mask;
    logic [CH_W-1:0]     w_nxt_sel3;
    logic                w_nxt_busy;
    logic                w_nxt_done;
    logic [RES_W-1:0]    w_nxt_result;
    logic [NUM_CH-1:0]   w_nxt_valid;

    logic [NUM_CH-1:0]   w_find_mask;
    logic [CH_W-1:0]     w_find_cur;
    logic                w_find_bz;
    logic [CH_W-1:0]     w_find_next;
    logic                w_find_ok;

    // One finder serves both lookups: in IDLE it searches the live mask for
    // the first channel, otherwise it steps through the latched mask.
    assign w_find_mask = (r_state == IDLE) ? i_chan_en : r_mask;
    assign w_find_cur  = r_sel3;
    assign w_find_bz   = (r_state == IDLE);

    next_chan_finder u_finder (
        .i_mask       (w_find_mask),
        .i_cur        (w_find_cur),
        .i_below_zero (w_find_bz),
        .o_next       (w_find_next),
        .o_found      (w_find_ok)
    );

    always_comb begin
        w_nxt_state  = r_state;
        w_nxt_cnt    = r_cnt;
        w_nxt_dwell  = r_dwell;
        w_nxt_mask   = r_mask;
        w_nxt_sel3   = r_sel3;
        w_nxt_busy   = r_busy;
        w_nxt_done   = 1'b0;
        w_nxt_result = r_result;
        w_nxt_valid  = r_valid;

        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_nxt_result = '0;
                    w_nxt_valid  = '0;
                    if (i_chan_en != '0) begin
                        w_nxt_mask  = i_chan_en;
                        w_nxt_dwell = i_dwell;
                        w_nxt_cnt   = i_dwell;
                        w_nxt_sel3  = w_find_next;
                        w_nxt_busy  = 1'b1;
                        w_nxt_state = DWELL;
                    end else begin
                        w_nxt_done  = 1'b1;
                        w_nxt_state = DONE;
                    end
                end
            end

            DWELL: begin
                if (r_cnt != '0) begin
                    w_nxt_cnt = r_cnt - DWELL_W'(1);
                end else begin
                    // End of this channel's dwell: capture the settled mux value.
                    for (int k = 0; k < NUM_CH; k++) begin
                        if (r_sel3 == CH_W'(k)) begin
                            w_nxt_result[k*CH_W +: CH_W] = i_mux_out;
                            w_nxt_valid[k]               = 1'b1;
                        end
                    end
                    if (w_find_ok) begin
                        w_nxt_sel3 = w_find_next;
                        w_nxt_cnt  = r_dwell;
                    end else begin
                        w_nxt_busy  = 1'b0;
                        w_nxt_done  = 1'b1;
                        w_nxt_state = DONE;
                    end
                end
            end

            DONE: begin
                w_nxt_state = IDLE;
            end

            default: begin
                w_nxt_state = IDLE;
                w_nxt_busy  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_dwell  <= '0;
            r_mask   <= '0;
            r_sel3   <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_valid  <= '0;
        end else begin
            r_state  <= w_nxt_state;
            r_cnt    <= w_nxt_cnt;
            r_dwell  <= w_nxt_dwell;
            r_mask   <= w_nxt_mask;
            r_sel3   <= w_nxt_sel3;
            r_busy   <= w_nxt_busy;
            r_done   <= w_nxt_done;
            r_result <= w_nxt_result;
            r_valid  <= w_nxt_valid;
        end
    end

    assign o_sel3       = r_sel3;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_result     = r_result;
    assign o_valid_mask = r_valid;

endmodule : scan_sequencer
`default_nettype wire

// File: tb/tb_scan_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_scan_sequencer
//  Description : Self-checking bench for scan_sequencer. A behavioural mux
//                feeds mux_out from the selected source; scans are checked
//                against expectations derived from the enable mask, dwell
//                and source values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_scan_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start;
    logic [3:0]  i_dwell;
    logic [7:0]  i_chan_en;
    logic [2:0]  i_mux_out;
    logic [2:0]  o_sel3;
    logic        o_busy;
    logic        o_done;
    logic [23:0] o_result;
    logic [7:0]  o_valid_mask;

    logic [23:0] tb_vals;
    logic        ov_en;
    logic [2:0]  ov_val;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Source k sits at tb_vals[3k+2:3k]; an override forces the mux output.
    always_comb begin
        i_mux_out = tb_vals[int'(o_sel3)*3 +: 3];
        if (ov_en) i_mux_out = ov_val;
    end

    scan_sequencer #(.DWELL_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_start      (i_start),
        .i_dwell      (i_dwell),
        .i_chan_en    (i_chan_en),
        .i_mux_out    (i_mux_out),
        .o_sel3       (o_sel3),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_result     (o_result),
        .o_valid_mask (o_valid_mask)
    );

    typedef struct {
        string       name;
        logic [7:0]  en;
        logic [3:0]  dw;
        logic [23:0] vals;
        logic [23:0] exp_res;
        logic [7:0]  exp_val;
        int          exp_busy;
        bit          mid_start;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issues a start and follows the scan to its done pulse, comparing the
    // select sequence, busy length, done timing and captured data.
    task automatic run_scan(input string name, input logic [7:0] en, input logic [3:0] dw,
                            input logic [23:0] vals, input logic [23:0] exp_res,
                            input logic [7:0] exp_val, input int exp_busy, input bit mid_start);
        int q[$];
        int busy_cnt;
        int sel_bad;
        int done_at;
        int top;
        bit seen_done;
        top = -1;
        for (int k = 0; k < 8; k++) begin
            if (en[k]) begin
                top = k;
                for (int r = 0; r <= int'(dw); r++) q.push_back(k);
            end
        end
        tb_vals   = vals;
        i_chan_en = en;
        i_dwell   = dw;
        i_start   = 1'b1;
        step();
        i_start   = 1'b0;
        i_chan_en = 8'($urandom);
        i_dwell   = 4'($urandom);
        busy_cnt  = 0;
        sel_bad   = 0;
        done_at   = -1;
        seen_done = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (mid_start && c == 2) begin
                i_start   = 1'b1;
                i_chan_en = ~en;
                i_dwell   = dw + 4'd3;
            end
            if (o_done) begin
                seen_done = 1'b1;
                done_at   = c;
                break;
            end
            if (o_busy) begin
                if (busy_cnt >= q.size() || int'(o_sel3) != q[busy_cnt]) sel_bad++;
                busy_cnt++;
            end
            step();
        end
        check({name, "_done_seen"}, 32'(seen_done), 32'd1);
        check({name, "_done_cycle"}, 32'(done_at), 32'(exp_busy));
        check({name, "_busy_len"}, 32'(busy_cnt), 32'(exp_busy));
        check({name, "_sel_seq_errs"}, 32'(sel_bad), 32'd0);
        check({name, "_result"}, 32'(o_result), 32'(exp_res));
        check({name, "_valid"}, 32'(o_valid_mask), 32'(exp_val));
        check({name, "_busy_in_done"}, 32'(o_busy), 32'd0);
        if (top >= 0) check({name, "_sel_hold"}, 32'(o_sel3), 32'(top));
        step();
        i_start = 1'b0;
        check({name, "_done_once"}, 32'(o_done), 32'd0);
        check({name, "_idle_busy"}, 32'(o_busy), 32'd0);
    endtask

    vec_t vecs[$];

    initial begin
        logic [7:0]  en;
        logic [3:0]  dw;
        logic [23:0] vals;
        logic [23:0] res;
        bit          found;

        vecs.push_back('{"full",    8'hFF, 4'd0,  24'hFAC688, 24'hFAC688, 8'hFF, 8,  1'b0});
        vecs.push_back('{"sparse",  8'hA4, 4'd3,  24'hFAC688, 24'hE28080, 8'hA4, 12, 1'b0});
        vecs.push_back('{"empty",   8'h00, 4'd5,  24'hFAC688, 24'h000000, 8'h00, 0,  1'b0});
        vecs.push_back('{"ignored", 8'hA4, 4'd3,  24'hFAC688, 24'hE28080, 8'hA4, 12, 1'b1});
        vecs.push_back('{"maxdw",   8'h81, 4'd15, 24'hFAC688, 24'hE00000, 8'h81, 32, 1'b0});
        vecs.push_back('{"top1",    8'h80, 4'd1,  24'hFFFFFF, 24'hE00000, 8'h80, 2,  1'b0});

        rst       = 1'b1;
        i_start   = 1'b1;
        i_dwell   = 4'd0;
        i_chan_en = 8'hFF;
        tb_vals   = 24'hFAC688;
        ov_en     = 1'b0;
        ov_val    = 3'd0;
        repeat (3) step();
        check("rst_sel3",   32'(o_sel3), 32'd0);
        check("rst_busy",   32'(o_busy), 32'd0);
        check("rst_done",   32'(o_done), 32'd0);
        check("rst_result", 32'(o_result), 32'd0);
        check("rst_valid",  32'(o_valid_mask), 32'd0);
        i_start = 1'b0;
        rst     = 1'b0;
        step();

        foreach (vecs[i]) begin
            run_scan(vecs[i].name, vecs[i].en, vecs[i].dw, vecs[i].vals,
                     vecs[i].exp_res, vecs[i].exp_val, vecs[i].exp_busy, vecs[i].mid_start);
        end

        // Reset in mid-scan while channel 5 is selected.
        tb_vals   = 24'hFAC688;
        i_chan_en = 8'hFF;
        i_dwell   = 4'd0;
        i_start   = 1'b1;
        step();
        i_start = 1'b0;
        found   = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (o_sel3 == 3'd5 && o_busy) begin
                found = 1'b1;
                break;
            end
            step();
        end
        check("midrst_reach_sel5", 32'(found), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_sel3",   32'(o_sel3), 32'd0);
        check("midrst_busy",   32'(o_busy), 32'd0);
        check("midrst_result", 32'(o_result), 32'd0);
        check("midrst_valid",  32'(o_valid_mask), 32'd0);
        found = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (o_done || o_busy) found = 1'b1;
            step();
        end
        check("midrst_no_done", 32'(found), 32'd0);
        run_scan("after_rst", 8'hFF, 4'd0, 24'hFAC688, 24'hFAC688, 8'hFF, 8, 1'b0);

        // Capture edge: channel 1, dwell 2; value changes 1 -> 6 one cycle
        // before the capture edge and the later value must be stored.
        ov_en     = 1'b1;
        ov_val    = 3'd1;
        i_chan_en = 8'h02;
        i_dwell   = 4'd2;
        i_start   = 1'b1;
        step();
        i_start = 1'b0;
        step();
        step();
        ov_val = 3'd6;
        step();
        check("cap_done",   32'(o_done), 32'd1);
        check("cap_field",  32'(o_result), 32'h000030);
        check("cap_valid",  32'(o_valid_mask), 32'h02);
        step();
        ov_en = 1'b0;

        // Randomized scans against a plain reference of the scan rules.
        for (int n = 0; n < 24; n++) begin
            en   = 8'($urandom);
            if (n % 6 == 0) en = 8'h00;
            dw   = 4'($urandom_range(0, 15));
            vals = 24'($urandom);
            res  = '0;
            for (int k = 0; k < 8; k++) begin
                if (en[k]) res[k*3 +: 3] = vals[k*3 +: 3];
            end
            run_scan($sformatf("rand%0d", n), en, dw, vals, res, en,
                     $countones(en) * (int'(dw) + 1), (n % 5 == 4) && (en != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_scan_sequencer
`default_nettype wire
